// File: rtl/femto_bus_interconnect.sv
// Address decoder, strobe router and read mux between FemtoRV32 and NUM_SLAVES slaves.
// Holds the selected slot through busy stalls, bounds stalls with a timeout, keeps a sticky error record.
module femto_bus_interconnect #(
  parameter int unsigned NUM_SLAVES     = 8,
  parameter int unsigned DEC_BITS       = 16,
  parameter logic [NUM_SLAVES*DEC_BITS-1:0] BASE_MAP = {
    16'h8004, 16'h8003, 16'h8002, 16'h8001,
    16'h8000, 16'h0040, 16'h0001, 16'h0000
  },
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              mem_addr,
  input  logic [31:0]              mem_wdata,
  input  logic [3:0]               mem_wmask,
  input  logic                     mem_rstrb,
  output logic [31:0]              mem_rdata,
  output logic                     mem_rbusy,
  output logic                     mem_wbusy,
  output logic [NUM_SLAVES-1:0]    s_sel,
  output logic                     s_rd,
  output logic                     s_wr,
  output logic [31:0]              s_addr,
  output logic [31:0]              s_wdata,
  output logic [3:0]               s_wmask,
  input  logic [NUM_SLAVES*32-1:0] s_rdata,
  input  logic [NUM_SLAVES-1:0]    s_rbusy,
  input  logic [NUM_SLAVES-1:0]    s_wbusy,
  output logic                     err_flag,
  output logic [1:0]               err_cause,
  output logic [31:0]              err_addr,
  input  logic                     err_clr
);

  localparam int unsigned SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_t;

  state_t          state, state_n;
  logic [SW-1:0]   slot, slot_n, decoded;
  logic            mapped;
  logic [31:0]     cnt, cnt_n, cnt_inc;
  logic [31:0]     txn_addr, txn_addr_n;
  logic            wr_req;
  logic            err_set;
  logic [1:0]      err_code;
  logic [31:0]     err_at;

  assign s_addr  = mem_addr;
  assign s_wdata = mem_wdata;
  assign s_wmask = mem_wmask;
  assign wr_req  = |mem_wmask;
  assign cnt_inc = cnt + 32'd1;

  // Scan from the top down so the lowest matching slot is the one left standing.
  always_comb begin
    mapped  = 1'b0;
    decoded = '0;
    for (int unsigned i = NUM_SLAVES; i > 0; i--) begin
      if (mem_addr[31 -: DEC_BITS] == BASE_MAP[(i-1)*DEC_BITS +: DEC_BITS]) begin
        mapped  = 1'b1;
        decoded = SW'(i - 1);
      end
    end
  end

  always_comb begin
    state_n    = state;
    slot_n     = slot;
    cnt_n      = cnt;
    txn_addr_n = txn_addr;
    s_sel      = '0;
    s_rd       = 1'b0;
    s_wr       = 1'b0;
    mem_rdata  = '0;
    mem_rbusy  = 1'b0;
    mem_wbusy  = 1'b0;
    err_set    = 1'b0;
    err_code   = 2'b00;
    err_at     = mem_addr;
    case (state)
      IDLE: begin
        if (wr_req || mem_rstrb) begin
          if (wr_req && mem_rstrb) begin
            err_set  = 1'b1;
            err_code = 2'b11;
          end else if (!mapped) begin
            err_set  = 1'b1;
            err_code = 2'b01;
          end
          if (mapped) begin
            s_sel[decoded] = 1'b1;
            slot_n         = decoded;
            txn_addr_n     = mem_addr;
            if (wr_req) begin
              s_wr      = 1'b1;
              mem_wbusy = s_wbusy[decoded];
              if (s_wbusy[decoded]) begin
                state_n = WR_WAIT;
                cnt_n   = 32'd1;
              end
            end else begin
              s_rd      = 1'b1;
              mem_rbusy = s_rbusy[decoded];
              mem_rdata = s_rdata[32*int'(decoded) +: 32];
              if (s_rbusy[decoded]) begin
                state_n = RD_WAIT;
                cnt_n   = 32'd1;
              end
            end
          end
        end
      end
      RD_WAIT: begin
        s_sel[slot] = 1'b1;
        mem_rdata   = s_rdata[32*int'(slot) +: 32];
        mem_rbusy   = s_rbusy[slot];
        if (!s_rbusy[slot]) begin
          state_n = IDLE;
        end else begin
          cnt_n = cnt_inc;
          if (TIMEOUT_CYCLES != 0 && cnt_inc >= 32'(TIMEOUT_CYCLES)) begin
            mem_rbusy = 1'b0;
            mem_rdata = ERR_DATA;
            state_n   = IDLE;
            err_set   = 1'b1;
            err_code  = 2'b10;
            err_at    = txn_addr;
          end
        end
      end
      WR_WAIT: begin
        s_sel[slot] = 1'b1;
        mem_wbusy   = s_wbusy[slot];
        if (!s_wbusy[slot]) begin
          state_n = IDLE;
        end else begin
          cnt_n = cnt_inc;
          if (TIMEOUT_CYCLES != 0 && cnt_inc >= 32'(TIMEOUT_CYCLES)) begin
            mem_wbusy = 1'b0;
            state_n   = IDLE;
            err_set   = 1'b1;
            err_code  = 2'b10;
            err_at    = txn_addr;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      slot      <= '0;
      cnt       <= '0;
      txn_addr  <= '0;
      err_flag  <= 1'b0;
      err_cause <= 2'b00;
      err_addr  <= '0;
    end else begin
      state    <= state_n;
      slot     <= slot_n;
      cnt      <= cnt_n;
      txn_addr <= txn_addr_n;
      // A new error in the clearing cycle is captured rather than lost.
      if (err_set && (!err_flag || err_clr)) begin
        err_flag  <= 1'b1;
        err_cause <= err_code;
        err_addr  <= err_at;
      end else if (err_clr) begin
        err_flag  <= 1'b0;
        err_cause <= 2'b00;
      end
    end
  end

endmodule
